// File: rtl/counter_pkg.sv
// Shared constants and operation encoding for the up/down counter slice.
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  typedef enum logic [1:0] {
    CLEAR,
    LOAD,
    INCR,
    HOLD
  } cnt_op_e;

  // Priority: clear > load > incr > hold.
  function automatic cnt_op_e cnt_decode(input logic i_clear, input logic i_load,
                                         input logic i_incr);
    cnt_op_e op;
    op = HOLD;
    if (i_clear)     op = CLEAR;
    else if (i_load) op = LOAD;
    else if (i_incr) op = INCR;
    return op;
  endfunction

endpackage

// File: rtl/cnt_next_val.sv
// Combinational next-count, wrap/terminal pulse and cascade terminal-count flag.
// Saturation is only built when UPDNCNT_SAT_EN is defined.
module cnt_next_val
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic             i_dir,
  input  logic [WIDTH-1:0] i_limit,
  input  logic             i_sat,
  output logic [WIDTH-1:0] o_q_next,
  output logic             o_c_next,
  output logic             o_tc
);

  logic w_at_up;
  logic w_at_dn;
  logic w_sat;

  // ">=" so a loaded value above limit is treated as terminal when counting up.
  assign w_at_up = (i_q >= i_limit);
  assign w_at_dn = (i_q == '0);
  assign o_tc    = ((i_dir == CNT_UP) & w_at_up) | ((i_dir == CNT_DOWN) & w_at_dn);

`ifdef UPDNCNT_SAT_EN
  assign w_sat = i_sat;
`else
  logic w_unused_sat;
  assign w_unused_sat = i_sat;
  assign w_sat        = 1'b0;
`endif

  always_comb begin
    o_q_next = i_q;
    o_c_next = 1'b0;
    if (i_dir == CNT_UP) begin
      if (w_at_up) begin
        o_c_next = 1'b1;
        o_q_next = w_sat ? i_limit : '0;
      end else begin
        o_q_next = i_q + 1'b1;
      end
    end else begin
      if (w_at_dn) begin
        o_c_next = 1'b1;
        o_q_next = w_sat ? '0 : i_limit;
      end else begin
        o_q_next = i_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/updown_counter_n.sv
// Parametrised up/down counter: programmable limit, parallel load, registered
// wrap pulse c and combinational cascade flag tc. Optional saturation: UPDNCNT_SAT_EN.
module updown_counter_n
  import counter_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             incr,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic             sat,
  output logic [WIDTH-1:0] q,
  output logic             c,
  output logic             tc
);

  cnt_op_e          w_op;
  logic [WIDTH-1:0] r_q;
  logic             r_c;
  logic [WIDTH-1:0] w_q_next;
  logic             w_c_next;

  cnt_next_val #(
    .WIDTH(WIDTH)
  ) u_next (
    .i_q     (r_q),
    .i_dir   (dir),
    .i_limit (limit),
    .i_sat   (sat),
    .o_q_next(w_q_next),
    .o_c_next(w_c_next),
    .o_tc    (tc)
  );

  always_comb begin
    w_op = cnt_decode(clear, load, incr);
  end

  always_ff @(posedge clk) begin
    case (w_op)
      CLEAR: begin
        r_q <= RESET_VAL;
        r_c <= 1'b0;
      end
      LOAD: begin
        r_q <= d;
        r_c <= 1'b0;
      end
      INCR: begin
        r_q <= w_q_next;
        r_c <= w_c_next;
      end
      default: begin
        r_c <= 1'b0;
      end
    endcase
  end

  assign q = r_q;
  assign c = r_c;

endmodule
